// File: rtl/image_stream_source.sv
// image_stream_source
// Producer side of the image stream feeding the CNN feature extractor.
// Takes raw loader words: one header word carrying the square image side,
// then side*side pixel words, which are forwarded with one cycle of latency.
//
// Optional build macro: HEADER_MAGIC_CHECK_EN
//   defined   : a header also needs 16'hC0DE in its top 16 bits.
//   undefined : only the side range 1..MAX_IMAGE_SIZE is checked.
//
// Handshake: a loader word moves when in_valid && in_ready are both high at a
// rising data_clk edge. in_ready is a registered output that never depends
// combinationally on in_valid. There is no back-pressure from the consumer:
// image_valid is a one-cycle strobe, image_data holds between strobes.
//
// o_dbg_state exposes the FSM encoding (0 IDLE, 1 STREAM, 2 DONE).

module image_stream_source #(
  parameter int DATA_WIDTH          = 32,
  parameter int MAX_IMAGE_SIZE      = 512,
  parameter int MAX_IMAGE_SIZE_LOG2 = 9
) (
  input  logic                           data_clk,
  input  logic                           data_rst,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           in_ready,
  input  logic                           frame_abort,
  output logic                           size_detection_done,
  output logic [MAX_IMAGE_SIZE_LOG2:0]   image_size,
  output logic [DATA_WIDTH-1:0]          image_data,
  output logic                           image_valid,
  output logic                           frame_done,
  output logic                           header_error,
  output logic [1:0]                     o_dbg_state
);

  // Side field width and pixel counter width (full square, no truncation).
  localparam int SW = MAX_IMAGE_SIZE_LOG2 + 1;
  localparam int CW = 2 * SW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic                r_in_ready;
  logic                r_sdd;
  logic [SW-1:0]       r_image_size;
  logic [DATA_WIDTH-1:0] r_image_data;
  logic                r_image_valid;
  logic                r_frame_done;
  logic                r_header_error;
  logic [CW-1:0]       r_count;

  logic                w_in_ready_nxt;
  logic                w_sdd_nxt;
  logic [SW-1:0]       w_image_size_nxt;
  logic [DATA_WIDTH-1:0] w_image_data_nxt;
  logic                w_image_valid_nxt;
  logic                w_frame_done_nxt;
  logic                w_header_error_nxt;
  logic [CW-1:0]       w_count_nxt;

  logic                w_xfer;
  logic [SW-1:0]       w_side;
  logic                w_side_ok;
  logic                w_magic_ok;
  logic                w_hdr_ok;
  logic                w_last;
  logic [CW-1:0]       w_side_sq;

  // Header decode and transfer qualification.
  assign w_xfer    = in_valid && r_in_ready;
  assign w_side    = in_data[MAX_IMAGE_SIZE_LOG2:0];
  assign w_side_ok = (w_side != '0) && (w_side <= SW'(MAX_IMAGE_SIZE));
  assign w_side_sq = CW'(w_side) * CW'(w_side);
  assign w_last    = (r_count == CW'(1));

`ifdef HEADER_MAGIC_CHECK_EN
  assign w_magic_ok = (in_data[DATA_WIDTH-1:DATA_WIDTH-16] == 16'hC0DE);
`else
  assign w_magic_ok = 1'b1;
`endif

  assign w_hdr_ok = w_side_ok && w_magic_ok;

  // State register.
  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort wins over a simultaneous last-pixel transfer.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_xfer && w_hdr_ok) begin
          w_next_state = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (frame_abort) begin
          w_next_state = ST_IDLE;
        end else if (w_xfer && w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output/datapath next values for the registered outputs and counter.
  always_comb begin
    w_in_ready_nxt     = (w_next_state != ST_DONE);
    w_sdd_nxt          = r_sdd;
    w_image_size_nxt   = r_image_size;
    w_image_data_nxt   = r_image_data;
    w_image_valid_nxt  = 1'b0;
    w_frame_done_nxt   = 1'b0;
    w_header_error_nxt = 1'b0;
    w_count_nxt        = r_count;
    unique case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (w_hdr_ok) begin
            w_image_size_nxt = w_side;
            w_count_nxt      = w_side_sq;
            w_sdd_nxt        = 1'b1;
          end else begin
            w_header_error_nxt = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (frame_abort) begin
          // Partial frame dropped; any word presented now is discarded.
          w_sdd_nxt   = 1'b0;
          w_count_nxt = '0;
        end else if (w_xfer) begin
          w_image_data_nxt  = in_data;
          w_image_valid_nxt = 1'b1;
          w_count_nxt       = r_count - CW'(1);
        end
      end
      ST_DONE: begin
        // The last pixel is on the outputs this cycle; close the frame next.
        w_frame_done_nxt = 1'b1;
        w_sdd_nxt        = 1'b0;
      end
      default: begin
        w_sdd_nxt   = 1'b0;
        w_count_nxt = '0;
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      r_in_ready     <= 1'b0;
      r_sdd          <= 1'b0;
      r_image_size   <= '0;
      r_image_data   <= '0;
      r_image_valid  <= 1'b0;
      r_frame_done   <= 1'b0;
      r_header_error <= 1'b0;
      r_count        <= '0;
    end else begin
      r_in_ready     <= w_in_ready_nxt;
      r_sdd          <= w_sdd_nxt;
      r_image_size   <= w_image_size_nxt;
      r_image_data   <= w_image_data_nxt;
      r_image_valid  <= w_image_valid_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_header_error <= w_header_error_nxt;
      r_count        <= w_count_nxt;
    end
  end

  assign in_ready            = r_in_ready;
  assign size_detection_done = r_sdd;
  assign image_size          = r_image_size;
  assign image_data          = r_image_data;
  assign image_valid         = r_image_valid;
  assign frame_done          = r_frame_done;
  assign header_error        = r_header_error;
  assign o_dbg_state         = r_state;

  // A pixel strobe only ever appears inside an accepted frame.
  a_valid_in_frame : assert property (@(posedge data_clk) disable iff (data_rst)
    image_valid |-> size_detection_done);

  // The frame is closed by the time frame_done is reported.
  a_done_closed : assert property (@(posedge data_clk) disable iff (data_rst)
    frame_done |-> !size_detection_done);

endmodule
